// File: rtl/video_wfifo_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_wfifo_pkg
// Brief    : Shared state type and constants for the video write-FIFO packer.
// Revision : 1.0 - initial release
// ============================================================================
package video_wfifo_pkg;

   localparam int c_pix_w = 16;

   typedef enum logic [2:0] {
      WAIT_VS = 3'd0,
      HOLD    = 3'd1,
      SYNC    = 3'd2,
      ACTIVE  = 3'd3,
      DONE    = 3'd4
   } state_t;

   // Bar colours left to right: white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [c_pix_w-1:0] c_bar_colors [0:7] = '{
      16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
      16'hF81F, 16'hF800, 16'h001F, 16'h0000
   };

endpackage
`default_nettype wire

// File: rtl/video_wfifo_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : video_wfifo_packer_if
// Brief    : Video-in / write-FIFO-out bundle for the packer.
// Revision : 1.0 - initial release
// ============================================================================
interface video_wfifo_packer_if;
   import video_wfifo_pkg::*;

   logic                 vid_vs;
   logic                 vid_de;
   logic [c_pix_w-1:0]   vid_data;
   logic                 wfifo_wr_en;
   logic [2*c_pix_w-1:0] wfifo_wr_data32;
   logic                 frame_vs;
   logic                 frame_done;
   logic                 err_line_short;
   logic                 err_frame_short;

   modport slave (
      input  vid_vs, vid_de, vid_data,
      output wfifo_wr_en, wfifo_wr_data32, frame_vs, frame_done,
             err_line_short, err_frame_short
   );

   modport master (
      output vid_vs, vid_de, vid_data,
      input  wfifo_wr_en, wfifo_wr_data32, frame_vs, frame_done,
             err_line_short, err_frame_short
   );

endinterface
`default_nettype wire

// File: rtl/video_wfifo_packer_pixel_pair_packer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_pair_packer
// Brief    : Pairs 16-bit pixels into 32-bit words; pads an odd last pixel.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_pair_packer
   import video_wfifo_pkg::*;
(
   input  wire logic                 wfifo_wr_clk,
   input  wire logic                 rstn,
   input  wire logic                 i_pix_valid,
   input  wire logic [c_pix_w-1:0]   i_pix_data,
   input  wire logic                 i_line_end,
   input  wire logic                 i_discard,
   output logic                      o_wr_en,
   output logic [2*c_pix_w-1:0]      o_wr_data
);

   logic                 r_half_valid;
   logic [c_pix_w-1:0]   r_half;
   logic                 r_wr_en;
   logic [2*c_pix_w-1:0] r_wr_data;

   // i_pix_valid and i_line_end never coincide: a line end needs de low.
   always_ff @(posedge wfifo_wr_clk) begin
      if (!rstn) begin
         r_half_valid <= 1'b0;
         r_half       <= '0;
         r_wr_en      <= 1'b0;
         r_wr_data    <= '0;
      end else begin
         r_wr_en <= 1'b0;
         if (i_discard) begin
            r_half_valid <= 1'b0;
         end else if (i_pix_valid) begin
            if (r_half_valid) begin
               r_wr_en      <= 1'b1;
               r_wr_data    <= {i_pix_data, r_half};
               r_half_valid <= 1'b0;
            end else begin
               r_half       <= i_pix_data;
               r_half_valid <= 1'b1;
            end
         end else if (i_line_end && r_half_valid) begin
            r_wr_en      <= 1'b1;
            r_wr_data    <= {{c_pix_w{1'b0}}, r_half};
            r_half_valid <= 1'b0;
         end
      end
   end

   assign o_wr_en   = r_wr_en;
   assign o_wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: rtl/video_wfifo_packer.sv
`default_nettype none
// ============================================================================
// Module   : video_wfifo_packer
// Brief    : Frame-aligned RGB565 pair packer feeding the DDR write FIFO.
//            Optional macro TEST_PATTERN_EN replaces vid_data with colour bars.
// Revision : 1.0 - initial release
// ============================================================================
module video_wfifo_packer
   import video_wfifo_pkg::*;
#(
   parameter int H_ACT   = 960,
   parameter int V_ACT   = 540,
   parameter int HOLDOFF = 16
)(
   input  wire logic           wfifo_wr_clk,
   input  wire logic           rstn,
   video_wfifo_packer_if.slave bus
);

   localparam int c_pix_cw  = $clog2(H_ACT + 1);
   localparam int c_line_cw = $clog2(V_ACT + 1);
   localparam int c_hold_cw = $clog2(HOLDOFF + 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_vs;
   logic                  r_de;
   logic [c_pix_cw-1:0]   r_pix_cnt;
   logic [c_line_cw-1:0]  r_line_cnt;
   logic [c_hold_cw-1:0]  r_hold_cnt;
   logic                  r_frame_done;
   logic                  r_err_line_short;
   logic                  r_err_frame_short;

   logic                  w_vs_rise;
   logic                  w_de_fall;
   logic                  w_pix_valid;
   logic                  w_line_end;
   logic                  w_line_short;
   logic                  w_frame_short;
   logic                  w_frame_last;
   logic [c_pix_w-1:0]    w_pix_data;

   assign w_vs_rise = bus.vid_vs & ~r_vs;
   assign w_de_fall = ~bus.vid_de & r_de;

`ifdef TEST_PATTERN_EN
   logic [2:0] w_bar;
   assign w_bar      = 3'((32'(r_pix_cnt) * 32'd8) / 32'(H_ACT));
   assign w_pix_data = c_bar_colors[w_bar];
`else
   assign w_pix_data = bus.vid_data;
`endif

   always_ff @(posedge wfifo_wr_clk) begin
      if (!rstn) r_state <= WAIT_VS;
      else       r_state <= w_state_nxt;
   end

   // A vsync rise overrides everything else, whatever the current state.
   always_comb begin
      w_state_nxt   = r_state;
      w_pix_valid   = 1'b0;
      w_line_end    = 1'b0;
      w_line_short  = 1'b0;
      w_frame_short = 1'b0;
      w_frame_last  = 1'b0;
      if (w_vs_rise) begin
         w_state_nxt   = HOLD;
         w_frame_short = (r_state == ACTIVE);
      end else begin
         case (r_state)
            WAIT_VS, DONE: ;
            HOLD: begin
               if (r_hold_cnt == c_hold_cw'(HOLDOFF - 1))
                  w_state_nxt = bus.vid_vs ? SYNC : ACTIVE;
            end
            SYNC: begin
               if (!bus.vid_vs) w_state_nxt = ACTIVE;
            end
            ACTIVE: begin
               w_pix_valid = bus.vid_de && (r_pix_cnt < c_pix_cw'(H_ACT));
               if (w_de_fall) begin
                  w_line_end   = 1'b1;
                  w_line_short = (r_pix_cnt < c_pix_cw'(H_ACT));
                  if (r_line_cnt == c_line_cw'(V_ACT - 1)) begin
                     w_frame_last = 1'b1;
                     w_state_nxt  = DONE;
                  end
               end
            end
            default: w_state_nxt = WAIT_VS;
         endcase
      end
   end

   always_ff @(posedge wfifo_wr_clk) begin
      if (!rstn) begin
         r_vs              <= 1'b0;
         r_de              <= 1'b0;
         r_pix_cnt         <= '0;
         r_line_cnt        <= '0;
         r_hold_cnt        <= '0;
         r_frame_done      <= 1'b0;
         r_err_line_short  <= 1'b0;
         r_err_frame_short <= 1'b0;
      end else begin
         r_vs              <= bus.vid_vs;
         r_de              <= bus.vid_de;
         r_frame_done      <= w_frame_last;
         r_err_line_short  <= w_line_short;
         r_err_frame_short <= w_frame_short;

         if (w_vs_rise)              r_hold_cnt <= '0;
         else if (r_state == HOLD)   r_hold_cnt <= r_hold_cnt + 1'b1;

         if (w_vs_rise) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
         end else if (w_line_end) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= r_line_cnt + 1'b1;
         end else if (w_pix_valid) begin
            r_pix_cnt  <= r_pix_cnt + 1'b1;
         end
      end
   end

   pixel_pair_packer u_packer (
      .wfifo_wr_clk (wfifo_wr_clk),
      .rstn         (rstn),
      .i_pix_valid  (w_pix_valid),
      .i_pix_data   (w_pix_data),
      .i_line_end   (w_line_end),
      .i_discard    (w_vs_rise),
      .o_wr_en      (bus.wfifo_wr_en),
      .o_wr_data    (bus.wfifo_wr_data32)
   );

   assign bus.frame_vs        = r_vs;
   assign bus.frame_done      = r_frame_done;
   assign bus.err_line_short  = r_err_line_short;
   assign bus.err_frame_short = r_err_frame_short;

endmodule
`default_nettype wire
